// File: rtl/counter_sched.sv
// Programmable interval timer: prescaled wrapping up-counter with start/pause/resume/stop,
// one-shot or periodic reload, tick pulse and sticky irq. Define COUNTER_SCHED_OVERFLOW_EN
// to add the ovf_cnt missed-interrupt counter.
module counter_sched #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PSC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     cfg_period,
    input  logic [PSC_WIDTH-1:0] cfg_prescale,
    input  logic                 cfg_periodic,
    input  logic                 cmd_start,
    input  logic                 cmd_pause,
    input  logic                 cmd_stop,
    input  logic                 irq_clr,
    output logic [WIDTH-1:0]     cnt,
    output logic [1:0]           state,
    output logic                 busy,
    output logic                 tick,
`ifdef COUNTER_SCHED_OVERFLOW_EN
    output logic [7:0]           ovf_cnt,
`endif
    output logic                 irq
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     cnt_q;
    logic [PSC_WIDTH-1:0] psc_q;
    logic [WIDTH-1:0]     period_lat_q;
    logic [PSC_WIDTH-1:0] psc_lat_q;
    logic                 periodic_lat_q;
    logic                 busy_q;
    logic                 tick_q;
    logic                 irq_q;

    logic psc_wrap;
    logic step;
    logic terminal;

    // A step only happens in a RUN cycle that is neither stopped nor paused.
    always_comb begin
        psc_wrap = (psc_q == psc_lat_q);
        step     = (state_q == StRun) && !cmd_stop && !cmd_pause && psc_wrap;
        terminal = step && (cnt_q == period_lat_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            psc_q          <= '0;
            period_lat_q   <= '0;
            psc_lat_q      <= '0;
            periodic_lat_q <= 1'b0;
            busy_q         <= 1'b0;
            tick_q         <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (cmd_stop) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                psc_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (cmd_start) begin
                            period_lat_q   <= cfg_period;
                            psc_lat_q      <= cfg_prescale;
                            periodic_lat_q <= cfg_periodic;
                            cnt_q          <= '0;
                            psc_q          <= '0;
                            state_q        <= StRun;
                            busy_q         <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (cmd_pause) begin
                            state_q <= StPause;
                        end else if (!psc_wrap) begin
                            psc_q <= psc_q + PSC_WIDTH'(1);
                        end else begin
                            psc_q <= '0;
                            if (cnt_q != period_lat_q) begin
                                cnt_q <= cnt_q + WIDTH'(1);
                            end else begin
                                tick_q <= 1'b1;
                                if (periodic_lat_q) begin
                                    cnt_q <= '0;
                                end else begin
                                    state_q <= StDone;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end
                    end
                    StPause: begin
                        if (cmd_start) begin
                            state_q <= StRun;
                        end
                    end
                endcase
            end

            // Set wins over a simultaneous clear.
            if (terminal) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

`ifdef COUNTER_SCHED_OVERFLOW_EN
    logic [7:0] ovf_q;

    // Counts terminal steps that land while irq is still pending; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 8'd0;
        end else if (irq_clr) begin
            ovf_q <= 8'd0;
        end else if (terminal && irq_q && (ovf_q != 8'hff)) begin
            ovf_q <= ovf_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`endif

    assign cnt   = cnt_q;
    assign state = state_q;
    assign busy  = busy_q;
    assign tick  = tick_q;
    assign irq   = irq_q;

endmodule
